// File: rtl/draw_collectibles.sv
// Collectible-sprite overlay: draws up to N_PTS keyed sprites from a shared ROM at
// programmable positions, and clears sprites the player box touches.
module draw_collectibles #(
  parameter int          N_PTS   = 8,
  parameter int          IDX_W   = 3,
  parameter int          PT_SZ   = 16,
  parameter int          PL_W    = 32,
  parameter int          PL_H    = 32,
  parameter int          ROM_LAT = 2,
  parameter logic [11:0] KEY_RGB = 12'hF0F,
  localparam int         AW      = $clog2(PT_SZ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [10:0]       cfg_x,
  input  logic [10:0]       cfg_y,
  input  logic              en_load,
  input  logic [N_PTS-1:0]  en_mask_in,
  input  logic [10:0]       player_x,
  input  logic [10:0]       player_y,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out,
  output logic [2*AW-1:0]   pixel_addr,
  input  logic [11:0]       rgb_pixel,
  output logic              collect_stb,
  output logic [IDX_W-1:0]  collect_idx,
  output logic [4:0]        remaining,
  output logic              all_done
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } video_t;

  logic [10:0]      shadowX_q [N_PTS];
  logic [10:0]      shadowY_q [N_PTS];
  logic [10:0]      activeX_q [N_PTS];
  logic [10:0]      activeY_q [N_PTS];
  logic [N_PTS-1:0] enable_q, enable_d;
  logic             armed_q, armed_d;
  logic             collectStb_d;
  logic [IDX_W-1:0] collectIdx_d;

  logic             drawHit;
  logic [2*AW-1:0]  pixelAddr_d, pixelAddr_q;
  logic [11:0]      hitDx, hitDy;
  logic [11:0]      hCnt12, vCnt12, plX12, plY12;
  logic             colFound;
  logic [IDX_W-1:0] colIdx;
  logic [4:0]       enCount;
  logic             frameStart;

  video_t           videoIn;
  video_t           vidPipe_q [ROM_LAT+1];
  logic [11:0]      rgbPipe_q [ROM_LAT];
  logic             hitPipe_q [ROM_LAT];
  logic [11:0]      rgbOut_q;
  logic             collectStb_q;
  logic [IDX_W-1:0] collectIdx_q;
  logic [4:0]       remaining_q;
  logic             allDone_q;

  assign hCnt12     = {1'b0, hcount_in};
  assign vCnt12     = {1'b0, vcount_in};
  assign plX12      = {1'b0, player_x};
  assign plY12      = {1'b0, player_y};
  assign frameStart = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign videoIn    = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  // Positions take effect only at the top-left pixel so a frame never shows a half-moved sprite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PTS; i++) begin
        shadowX_q[i] <= '0;
        shadowY_q[i] <= '0;
        activeX_q[i] <= '0;
        activeY_q[i] <= '0;
      end
    end else begin
      if (cfg_we && (int'(cfg_idx) < N_PTS)) begin
        shadowX_q[cfg_idx] <= cfg_x;
        shadowY_q[cfg_idx] <= cfg_y;
      end
      if (frameStart) begin
        activeX_q <= shadowX_q;
        activeY_q <= shadowY_q;
      end
    end
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    drawHit     = 1'b0;
    pixelAddr_d = pixelAddr_q;
    hitDx       = '0;
    hitDy       = '0;
    for (int i = N_PTS-1; i >= 0; i--) begin
      hitDx = hCnt12 - {1'b0, activeX_q[i]};
      hitDy = vCnt12 - {1'b0, activeY_q[i]};
      if (enable_q[i] && (hCnt12 >= {1'b0, activeX_q[i]}) && (hitDx < 12'(PT_SZ)) &&
          (vCnt12 >= {1'b0, activeY_q[i]}) && (hitDy < 12'(PT_SZ))) begin
        drawHit     = 1'b1;
        pixelAddr_d = {hitDy[AW-1:0], hitDx[AW-1:0]};
      end
    end
  end

  always_comb begin
    colFound = 1'b0;
    colIdx   = '0;
    for (int i = N_PTS-1; i >= 0; i--) begin
      if (enable_q[i] &&
          (plX12 < {1'b0, activeX_q[i]} + 12'(PT_SZ)) && ({1'b0, activeX_q[i]} < plX12 + 12'(PL_W)) &&
          (plY12 < {1'b0, activeY_q[i]} + 12'(PT_SZ)) && ({1'b0, activeY_q[i]} < plY12 + 12'(PL_H))) begin
        colFound = 1'b1;
        colIdx   = IDX_W'(i);
      end
    end
  end

  // A mask load overrides any collection in the same cycle and suppresses its strobe.
  always_comb begin
    enable_d     = enable_q;
    armed_d      = armed_q;
    collectStb_d = 1'b0;
    collectIdx_d = '0;
    if (en_load) begin
      enable_d = en_mask_in;
      armed_d  = 1'b1;
    end else if (colFound) begin
      enable_d     = enable_q & ~(N_PTS'(1) << colIdx);
      collectStb_d = 1'b1;
      collectIdx_d = colIdx;
    end
  end

  always_comb begin
    enCount = '0;
    for (int i = 0; i < N_PTS; i++) begin
      enCount = enCount + 5'(enable_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q     <= '0;
      armed_q      <= 1'b0;
      collectStb_q <= 1'b0;
      collectIdx_q <= '0;
      remaining_q  <= '0;
      allDone_q    <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      armed_q      <= armed_d;
      collectStb_q <= collectStb_d;
      collectIdx_q <= collectIdx_d;
      remaining_q  <= enCount;
      allDone_q    <= armed_q && (enable_q == '0);
    end
  end

  // Hit flag and background colour ride alongside the ROM read so they meet rgb_pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixelAddr_q <= '0;
      rgbOut_q    <= '0;
      for (int k = 0; k <= ROM_LAT; k++) vidPipe_q[k] <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        rgbPipe_q[k] <= '0;
        hitPipe_q[k] <= 1'b0;
      end
    end else begin
      pixelAddr_q  <= pixelAddr_d;
      vidPipe_q[0] <= videoIn;
      rgbPipe_q[0] <= rgb_in;
      hitPipe_q[0] <= drawHit;
      for (int k = 1; k <= ROM_LAT; k++) vidPipe_q[k] <= vidPipe_q[k-1];
      for (int k = 1; k < ROM_LAT; k++) begin
        rgbPipe_q[k] <= rgbPipe_q[k-1];
        hitPipe_q[k] <= hitPipe_q[k-1];
      end
      rgbOut_q <= (hitPipe_q[ROM_LAT-1] && (rgb_pixel != KEY_RGB)) ? rgb_pixel
                                                                   : rgbPipe_q[ROM_LAT-1];
    end
  end

  assign hcount_out  = vidPipe_q[ROM_LAT].hcount;
  assign vcount_out  = vidPipe_q[ROM_LAT].vcount;
  assign hsync_out   = vidPipe_q[ROM_LAT].hsync;
  assign vsync_out   = vidPipe_q[ROM_LAT].vsync;
  assign hblnk_out   = vidPipe_q[ROM_LAT].hblnk;
  assign vblnk_out   = vidPipe_q[ROM_LAT].vblnk;
  assign rgb_out     = rgbOut_q;
  assign pixel_addr  = pixelAddr_q;
  assign collect_stb = collectStb_q;
  assign collect_idx = collectIdx_q;
  assign remaining   = remaining_q;
  assign all_done    = allDone_q;

endmodule

// File: tb/tb_draw_collectibles.sv
// Directed bench for draw_collectibles: vector table for the draw path plus hand-written
// sequences for latency, reset, shadow-bank swap and collection.
module tb_draw_collectibles;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [10:0] cfg_x, cfg_y;
  logic        en_load;
  logic [7:0]  en_mask_in;
  logic [10:0] player_x, player_y;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  pixel_addr;
  logic [11:0] rgb_pixel;
  logic        collect_stb;
  logic [2:0]  collect_idx;
  logic [4:0]  remaining;
  logic        all_done;

  logic [11:0] romVal;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        doLoad;
    logic [7:0]  mask;
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] rgbIn;
    logic [11:0] rom;
    logic [11:0] expRgb;
    logic [7:0]  expAddr;
  } vec_t;

  vec_t vecs [14];

  draw_collectibles dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .en_load(en_load), .en_mask_in(en_mask_in),
    .player_x(player_x), .player_y(player_y),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .collect_stb(collect_stb), .collect_idx(collect_idx),
    .remaining(remaining), .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM: one cycle from pixel_addr to data.
  always @(posedge clk) rgb_pixel <= romVal;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                               input logic [11:0] rgbIn, input logic [11:0] rom);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgbIn;
    romVal    = rom;
    repeat (4) tick();
  endtask

  task automatic loadEnable(input logic [7:0] mask);
    en_load    = 1'b1;
    en_mask_in = mask;
    tick();
    en_load    = 1'b0;
  endtask

  task automatic writeSlot(input logic [2:0] idx, input logic [10:0] x, input logic [10:0] y);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_x   = x;
    cfg_y   = y;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic frameTick();
    hcount_in = 11'd0;
    vcount_in = 11'd0;
    tick();
    hcount_in = 11'd500;
    vcount_in = 11'd300;
  endtask

  task automatic streamCheck(input int base);
    for (int n = 0; n < 8; n++) begin
      rgb_in    = 12'(base + n * 37);
      hcount_in = 11'(20 + n);
      vcount_in = 11'd5;
      hsync_in  = n[0];
      tick();
      if (n >= 2) begin
        checkOutput("streamRgb", 32'(rgb_out), 32'(12'(base + (n - 2) * 37)));
        checkOutput("streamHcount", 32'(hcount_out), 32'(20 + n - 2));
        checkOutput("streamHsync", 32'(hsync_out), 32'((n - 2) & 1));
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h07, 11'd100,  11'd200, 12'h123, 12'h0F0, 12'h0F0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 11'd115,  11'd215, 12'h124, 12'h0F0, 12'h0F0, 8'hFF};
    vecs[2]  = '{1'b0, 8'h00, 11'd116,  11'd215, 12'h456, 12'h0F0, 12'h456, 8'hFF};
    vecs[3]  = '{1'b0, 8'h00, 11'd107,  11'd203, 12'h125, 12'h0F0, 12'h0F0, 8'h37};
    vecs[4]  = '{1'b0, 8'h00, 11'd99,   11'd200, 12'hABC, 12'h0F0, 12'hABC, 8'h37};
    vecs[5]  = '{1'b0, 8'h00, 11'd110,  11'd199, 12'h777, 12'h0F0, 12'h777, 8'h37};
    vecs[6]  = '{1'b0, 8'h00, 11'd105,  11'd210, 12'h321, 12'hF0F, 12'h321, 8'hA5};
    vecs[7]  = '{1'b0, 8'h00, 11'd305,  11'd302, 12'h111, 12'h0F0, 12'h0F0, 8'h25};
    vecs[8]  = '{1'b1, 8'h05, 11'd305,  11'd302, 12'h112, 12'h0F0, 12'h0F0, 8'h69};
    vecs[9]  = '{1'b0, 8'h00, 11'd311,  11'd311, 12'h222, 12'h0F0, 12'h0F0, 8'hFF};
    vecs[10] = '{1'b0, 8'h00, 11'd312,  11'd311, 12'h333, 12'h0F0, 12'h333, 8'hFF};
    vecs[11] = '{1'b0, 8'h00, 11'd300,  11'd300, 12'h444, 12'h0F0, 12'h0F0, 8'h44};
    vecs[12] = '{1'b1, 8'h08, 11'd2045, 11'd405, 12'h555, 12'h0F0, 12'h0F0, 8'h55};
    vecs[13] = '{1'b0, 8'h00, 11'd7,    11'd405, 12'h666, 12'h0F0, 12'h666, 8'h55};

    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_x      = '0;
    cfg_y      = '0;
    en_load    = 1'b0;
    en_mask_in = '0;
    player_x   = 11'd1500;
    player_y   = 11'd1500;
    hcount_in  = 11'd33;
    vcount_in  = 11'd44;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    hblnk_in   = 1'b1;
    vblnk_in   = 1'b1;
    rgb_in     = 12'hABC;
    romVal     = 12'h0F0;

    repeat (3) tick();
    checkOutput("resetRgb", 32'(rgb_out), 32'h0);
    checkOutput("resetHcount", 32'(hcount_out), 32'h0);
    checkOutput("resetVcount", 32'(vcount_out), 32'h0);
    checkOutput("resetSync", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    checkOutput("resetAddr", 32'(pixel_addr), 32'h0);
    checkOutput("resetStb", 32'(collect_stb), 32'h0);
    checkOutput("resetIdx", 32'(collect_idx), 32'h0);
    checkOutput("resetRemaining", 32'(remaining), 32'h0);
    checkOutput("resetAllDone", 32'(all_done), 32'h0);

    rst      = 1'b0;
    vsync_in = 1'b0;
    hblnk_in = 1'b0;
    vblnk_in = 1'b0;
    repeat (4) tick();
    checkOutput("allDoneUnarmed", 32'(all_done), 32'h0);
    checkOutput("vblnkPass", 32'(vblnk_out), 32'h0);

    streamCheck(100);

    // Asynchronous reset partway through a line.
    #2 rst = 1'b1;
    #1;
    checkOutput("midResetRgb", 32'(rgb_out), 32'h0);
    checkOutput("midResetHcount", 32'(hcount_out), 32'h0);
    checkOutput("midResetVcount", 32'(vcount_out), 32'h0);
    #2 rst = 1'b0;

    streamCheck(900);

    writeSlot(3'd0, 11'd100, 11'd200);
    writeSlot(3'd1, 11'd300, 11'd300);
    writeSlot(3'd2, 11'd296, 11'd296);
    writeSlot(3'd3, 11'd2040, 11'd400);
    frameTick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].doLoad) loadEnable(vecs[i].mask);
      applyStimulus(vecs[i].h, vecs[i].v, vecs[i].rgbIn, vecs[i].rom);
      checkOutput($sformatf("vec%0dRgb", i), 32'(rgb_out), 32'(vecs[i].expRgb));
      checkOutput($sformatf("vec%0dAddr", i), 32'(pixel_addr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0dHcount", i), 32'(hcount_out), 32'(vecs[i].h));
      checkOutput($sformatf("vec%0dVcount", i), 32'(vcount_out), 32'(vecs[i].v));
    end

    // Shadow bank: mid-frame moves wait for the next (0,0).
    loadEnable(8'h01);
    hcount_in = 11'd500;
    vcount_in = 11'd300;
    writeSlot(3'd0, 11'd400, 11'd50);
    applyStimulus(11'd100, 11'd200, 12'h101, 12'h0F0);
    checkOutput("shadowOldRgb", 32'(rgb_out), 32'h0F0);
    checkOutput("shadowOldAddr", 32'(pixel_addr), 32'h00);
    applyStimulus(11'd405, 11'd52, 12'h202, 12'h0F0);
    checkOutput("shadowNewHiddenRgb", 32'(rgb_out), 32'h202);

    hcount_in = 11'd0;
    vcount_in = 11'd0;
    writeSlot(3'd0, 11'd600, 11'd60);
    applyStimulus(11'd405, 11'd52, 12'h303, 12'h0F0);
    checkOutput("shadowSwapRgb", 32'(rgb_out), 32'h0F0);
    checkOutput("shadowSwapAddr", 32'(pixel_addr), 32'h25);
    applyStimulus(11'd100, 11'd200, 12'h404, 12'h0F0);
    checkOutput("shadowOldGoneRgb", 32'(rgb_out), 32'h404);
    applyStimulus(11'd605, 11'd61, 12'h505, 12'h0F0);
    checkOutput("shadowSameCycleRgb", 32'(rgb_out), 32'h505);
    checkOutput("shadowSameCycleAddr", 32'(pixel_addr), 32'h25);
    frameTick();
    applyStimulus(11'd605, 11'd61, 12'h606, 12'h0F0);
    checkOutput("shadowLateRgb", 32'(rgb_out), 32'h0F0);
    checkOutput("shadowLateAddr", 32'(pixel_addr), 32'h15);

    // Collection of two overlapping slots, one per cycle.
    hcount_in  = 11'd500;
    vcount_in  = 11'd500;
    player_x   = 11'd290;
    player_y   = 11'd290;
    loadEnable(8'h06);
    checkOutput("collectLoadNoStb", 32'(collect_stb), 32'h0);
    tick();
    checkOutput("collectStb1", 32'(collect_stb), 32'h1);
    checkOutput("collectIdx1", 32'(collect_idx), 32'h1);
    checkOutput("collectRemaining2", 32'(remaining), 32'h2);
    checkOutput("collectNotDone", 32'(all_done), 32'h0);
    tick();
    checkOutput("collectStb2", 32'(collect_stb), 32'h1);
    checkOutput("collectIdx2", 32'(collect_idx), 32'h2);
    checkOutput("collectRemaining1", 32'(remaining), 32'h1);
    tick();
    checkOutput("collectStbEnd", 32'(collect_stb), 32'h0);
    checkOutput("collectRemaining0", 32'(remaining), 32'h0);
    checkOutput("collectAllDone", 32'(all_done), 32'h1);

    // Mask load in the same cycle as a pending collection wins and suppresses the strobe.
    player_x = 11'd1500;
    player_y = 11'd1500;
    loadEnable(8'h06);
    player_x = 11'd290;
    player_y = 11'd290;
    loadEnable(8'h02);
    checkOutput("loadPriorityNoStb", 32'(collect_stb), 32'h0);
    tick();
    checkOutput("loadPriorityStb", 32'(collect_stb), 32'h1);
    checkOutput("loadPriorityIdx", 32'(collect_idx), 32'h1);
    checkOutput("loadPriorityRemaining", 32'(remaining), 32'h1);
    tick();
    checkOutput("loadPriorityStbEnd", 32'(collect_stb), 32'h0);
    checkOutput("loadPriorityAllDone", 32'(all_done), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
